// File: rtl/lmt_entry_writer.sv
// rtl/lmt_entry_writer.sv - buffers LMT entries and splits them into per-slice PMT row writes
//
// Purpose: accepts 64-bit logical match table entries, queues them in a small
// FIFO together with the LMT's mapping (used, width gear, depth gear) sampled
// at acceptance, and issues one physical TCAM write per width slice.
//
// Optional build macro: LMT_WR_PARITY_EN adds output pmt_wr_parity.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   lmt_entry_valid/_ready           upstream entry handshake (ready = FIFO not full)
//   lmt_entry_id/_addr/_data/_mask   entry target LMT, logical row, key and mask
//   lmt_used, lmt_width_gear,        per-LMT mapping: enable, log2 slice count,
//   lmt_depth_gear                   log2 depth-block count
//   pmt_wr_valid/_ready              downstream write handshake
//   pmt_wr_lmt/_col/_blk/_addr       write target: LMT, slice, depth block, row
//   pmt_wr_data/_mask                slice payload
//   busy                             entry in flight or queued
//   drop_cnt, err_cnt                saturating counters: overflow drops, illegal entries
//   pmt_wr_parity                    (LMT_WR_PARITY_EN) XOR of {pmt_wr_data, pmt_wr_mask}
module lmt_entry_writer #(
  parameter int MAX_LMTS   = 5,
  parameter int PMT_WIDTH  = 32,
  parameter int PMT_DEPTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lmt_entry_valid,
  input  logic [2:0]              lmt_entry_id,
  input  logic [8:0]              lmt_entry_addr,
  input  logic [63:0]             lmt_entry_data,
  input  logic [63:0]             lmt_entry_mask,
  output logic                    lmt_entry_ready,
  input  logic [MAX_LMTS-1:0]     lmt_used,
  input  logic [MAX_LMTS*2-1:0]   lmt_width_gear,
  input  logic [MAX_LMTS*3-1:0]   lmt_depth_gear,
  output logic                    pmt_wr_valid,
  input  logic                    pmt_wr_ready,
  output logic [2:0]              pmt_wr_lmt,
  output logic [1:0]              pmt_wr_col,
  output logic [2:0]              pmt_wr_blk,
  output logic [$clog2(PMT_DEPTH)-1:0] pmt_wr_addr,
  output logic [PMT_WIDTH-1:0]    pmt_wr_data,
  output logic [PMT_WIDTH-1:0]    pmt_wr_mask,
  output logic                    busy,
  output logic [7:0]              drop_cnt,
  output logic [7:0]              err_cnt
`ifdef LMT_WR_PARITY_EN
  ,
  output logic                    pmt_wr_parity
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ROW_W = $clog2(PMT_DEPTH);

  typedef struct packed {
    logic [2:0]  id;
    logic [8:0]  addr;
    logic [63:0] data;
    logic [63:0] mask;
    logic        used;
    logic [1:0]  wg;
    logic [2:0]  dg;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  // Entry FIFO
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, empty, push, pop;
  entry_t           push_entry, head;

  // FSM and working registers
  state_t           state_q;
  logic [1:0]       k_q;
  logic             w_wide_q;
  logic [2:0]       w_id_q;
  logic [2:0]       w_blk_q;
  logic [ROW_W-1:0] w_row_q;
  logic [63:0]      w_data_q, w_mask_q;

  // Registered outputs
  logic                 pmt_wr_valid_q;
  logic [2:0]           pmt_wr_lmt_q;
  logic [1:0]           pmt_wr_col_q;
  logic [2:0]           pmt_wr_blk_q;
  logic [ROW_W-1:0]     pmt_wr_addr_q;
  logic [PMT_WIDTH-1:0] pmt_wr_data_q, pmt_wr_mask_q;
  logic [7:0]           drop_cnt_q, err_cnt_q;

  // Head decode
  logic [8:0]       head_blk;
  logic [ROW_W-1:0] head_row;
  logic             head_legal;

  // Mapping fields for the LMT addressed by the incoming entry; ids beyond
  // MAX_LMTS see used=0 and are therefore rejected as illegal at pop time.
  logic       sel_used;
  logic [1:0] sel_wg;
  logic [2:0] sel_dg;

  always_comb begin
    sel_used = 1'b0;
    sel_wg   = 2'd0;
    sel_dg   = 3'd0;
    for (int i = 0; i < MAX_LMTS; i++) begin
      if (lmt_entry_id == 3'(i)) begin
        sel_used = lmt_used[i];
        sel_wg   = lmt_width_gear[i*2 +: 2];
        sel_dg   = lmt_depth_gear[i*3 +: 3];
      end
    end
  end

  assign full            = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty           = (cnt_q == '0);
  assign lmt_entry_ready = ~full;
  assign push            = lmt_entry_valid & ~full;
  assign pop             = (state_q == ST_IDLE) & ~empty;

  always_comb begin
    push_entry      = '0;
    push_entry.id   = lmt_entry_id;
    push_entry.addr = lmt_entry_addr;
    push_entry.data = lmt_entry_data;
    push_entry.mask = lmt_entry_mask;
    push_entry.used = sel_used;
    push_entry.wg   = sel_wg;
    push_entry.dg   = sel_dg;
  end

  always_comb begin
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  assign head       = fifo_mem[rd_ptr_q];
  assign head_blk   = 9'(head.addr / PMT_DEPTH);
  assign head_row   = ROW_W'(head.addr % PMT_DEPTH);
  assign head_legal = head.used && (head.wg <= 2'd1) &&
                      ({23'd0, head_blk} < (32'd1 << head.dg));

  // Slice 0 is the most significant word of the entry.
  function automatic logic [PMT_WIDTH-1:0] pick_slice(input logic [63:0] v, input logic sel);
    return sel ? v[63-PMT_WIDTH -: PMT_WIDTH] : v[63 -: PMT_WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      state_q        <= ST_IDLE;
      k_q            <= 2'd0;
      w_wide_q       <= 1'b0;
      w_id_q         <= 3'd0;
      w_blk_q        <= 3'd0;
      w_row_q        <= '0;
      w_data_q       <= 64'd0;
      w_mask_q       <= 64'd0;
      pmt_wr_valid_q <= 1'b0;
      pmt_wr_lmt_q   <= 3'd0;
      pmt_wr_col_q   <= 2'd0;
      pmt_wr_blk_q   <= 3'd0;
      pmt_wr_addr_q  <= '0;
      pmt_wr_data_q  <= '0;
      pmt_wr_mask_q  <= '0;
      drop_cnt_q     <= 8'd0;
      err_cnt_q      <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (lmt_entry_valid && full && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end

      case (state_q)
        ST_IDLE: begin
          pmt_wr_valid_q <= 1'b0;
          if (!empty) begin
            k_q      <= 2'd0;
            w_wide_q <= head.wg[0];
            w_id_q   <= head.id;
            w_blk_q  <= head_blk[2:0];
            w_row_q  <= head_row;
            w_data_q <= head.data;
            w_mask_q <= head.mask;
            if (head_legal) begin
              state_q <= ST_ISSUE;
            end else if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (!pmt_wr_valid_q) begin
            // First cycle in ISSUE: present slice 0 from the working registers.
            pmt_wr_valid_q <= 1'b1;
            pmt_wr_lmt_q   <= w_id_q;
            pmt_wr_col_q   <= k_q;
            pmt_wr_blk_q   <= w_blk_q;
            pmt_wr_addr_q  <= w_row_q;
            pmt_wr_data_q  <= pick_slice(w_data_q, k_q[0]);
            pmt_wr_mask_q  <= pick_slice(w_mask_q, k_q[0]);
          end else if (pmt_wr_ready) begin
            k_q <= k_q + 2'd1;
            if (k_q[0] == w_wide_q) begin
              pmt_wr_valid_q <= 1'b0;
              state_q        <= ST_IDLE;
            end else begin
              pmt_wr_col_q  <= k_q + 2'd1;
              pmt_wr_data_q <= pick_slice(w_data_q, 1'b1);
              pmt_wr_mask_q <= pick_slice(w_mask_q, 1'b1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pmt_wr_valid = pmt_wr_valid_q;
  assign pmt_wr_lmt   = pmt_wr_lmt_q;
  assign pmt_wr_col   = pmt_wr_col_q;
  assign pmt_wr_blk   = pmt_wr_blk_q;
  assign pmt_wr_addr  = pmt_wr_addr_q;
  assign pmt_wr_data  = pmt_wr_data_q;
  assign pmt_wr_mask  = pmt_wr_mask_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign busy         = (state_q != ST_IDLE) | ~empty;

`ifdef LMT_WR_PARITY_EN
  assign pmt_wr_parity = ^{pmt_wr_data_q, pmt_wr_mask_q};
`endif

endmodule

// File: tb/tb_lmt_entry_writer.sv
// tb/tb_lmt_entry_writer.sv - randomized self-checking bench for lmt_entry_writer
//
// Purpose: drives directed and randomized entry traffic, predicts the PMT write
// sequence and counter values from the entry/mapping rules, and compares.
// Optional build macro: LMT_WR_PARITY_EN (parity output checked when defined).
module tb_lmt_entry_writer;

  typedef logic [76:0] wr_t; // {lmt, col, blk, addr, data, mask}

  logic        clk;
  logic        rst;
  logic        lmt_entry_valid;
  logic [2:0]  lmt_entry_id;
  logic [8:0]  lmt_entry_addr;
  logic [63:0] lmt_entry_data;
  logic [63:0] lmt_entry_mask;
  logic        lmt_entry_ready;
  logic [4:0]  cfg_used;
  logic [9:0]  cfg_wg;
  logic [14:0] cfg_dg;
  logic        pmt_wr_valid;
  logic        pmt_wr_ready;
  logic [2:0]  pmt_wr_lmt;
  logic [1:0]  pmt_wr_col;
  logic [2:0]  pmt_wr_blk;
  logic [4:0]  pmt_wr_addr;
  logic [31:0] pmt_wr_data;
  logic [31:0] pmt_wr_mask;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [7:0]  err_cnt;
`ifdef LMT_WR_PARITY_EN
  logic        pmt_wr_parity;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_err  = 0;
  int  exp_drop = 0;
  wr_t exp_q[$];

  lmt_entry_writer dut (
    .clk             (clk),
    .rst             (rst),
    .lmt_entry_valid (lmt_entry_valid),
    .lmt_entry_id    (lmt_entry_id),
    .lmt_entry_addr  (lmt_entry_addr),
    .lmt_entry_data  (lmt_entry_data),
    .lmt_entry_mask  (lmt_entry_mask),
    .lmt_entry_ready (lmt_entry_ready),
    .lmt_used        (cfg_used),
    .lmt_width_gear  (cfg_wg),
    .lmt_depth_gear  (cfg_dg),
    .pmt_wr_valid    (pmt_wr_valid),
    .pmt_wr_ready    (pmt_wr_ready),
    .pmt_wr_lmt      (pmt_wr_lmt),
    .pmt_wr_col      (pmt_wr_col),
    .pmt_wr_blk      (pmt_wr_blk),
    .pmt_wr_addr     (pmt_wr_addr),
    .pmt_wr_data     (pmt_wr_data),
    .pmt_wr_mask     (pmt_wr_mask),
    .busy            (busy),
    .drop_cnt        (drop_cnt),
    .err_cnt         (err_cnt)
`ifdef LMT_WR_PARITY_EN
    ,
    .pmt_wr_parity   (pmt_wr_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what one accepted entry must produce, from the mapping
  // sampled at acceptance.
  task automatic model_push();
    int         b, r;
    logic       u;
    logic [1:0] wg;
    logic [2:0] dg;
    wr_t        w;
    b  = int'(lmt_entry_addr) / 32;
    r  = int'(lmt_entry_addr) % 32;
    u  = 1'b0;
    wg = 2'd0;
    dg = 3'd0;
    if (lmt_entry_id < 3'd5) begin
      u  = cfg_used[lmt_entry_id];
      wg = cfg_wg[lmt_entry_id*2 +: 2];
      dg = cfg_dg[lmt_entry_id*3 +: 3];
    end
    if (!u || wg > 2'd1 || b >= (1 << dg)) begin
      if (exp_err < 255) exp_err++;
    end else begin
      for (int k = 0; k < (1 << wg); k++) begin
        w = {lmt_entry_id, 2'(k), 3'(b), 5'(r),
             (k == 0) ? lmt_entry_data[63:32] : lmt_entry_data[31:0],
             (k == 0) ? lmt_entry_mask[63:32] : lmt_entry_mask[31:0]};
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic send_entry(input logic [2:0] id, input logic [8:0] addr,
                            input logic [63:0] data, input logic [63:0] mask);
    lmt_entry_valid = 1'b1;
    lmt_entry_id    = id;
    lmt_entry_addr  = addr;
    lmt_entry_data  = data;
    lmt_entry_mask  = mask;
    model_push();
    tick();
    lmt_entry_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready);
    for (int i = 0; i < 300 && busy; i++) begin
      if (rnd_ready) pmt_wr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("idle_timeout", busy, 1'b0);
    pmt_wr_ready = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !pmt_wr_valid; i++) tick();
    check("valid_timeout", pmt_wr_valid, 1'b1);
  endtask

  // Write monitor: scoreboard on handshakes, stability while stalled.
  logic prev_stall = 1'b0;
  wr_t  prev_w;
  always @(negedge clk) begin
    wr_t cur;
    wr_t e;
    cur = {pmt_wr_lmt, pmt_wr_col, pmt_wr_blk, pmt_wr_addr, pmt_wr_data, pmt_wr_mask};
    if (prev_stall) begin
      check("stall_valid", pmt_wr_valid, 1'b1);
      check("stall_hold", cur, prev_w);
    end
    if (!rst && pmt_wr_valid === 1'b1 && pmt_wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", cur, 77'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr", cur, e);
`ifdef LMT_WR_PARITY_EN
        check("parity", pmt_wr_parity, ^e[63:0]);
`endif
      end
    end
    prev_stall = !rst && (pmt_wr_valid === 1'b1) && (pmt_wr_ready === 1'b0);
    prev_w     = cur;
  end

  initial begin
    rst             = 1'b1;
    lmt_entry_valid = 1'b0;
    lmt_entry_id    = 3'd0;
    lmt_entry_addr  = 9'd0;
    lmt_entry_data  = 64'd0;
    lmt_entry_mask  = 64'd0;
    pmt_wr_ready    = 1'b0;
    // LMT0: wg=1 dg=0; LMT1: wg=1 dg=3; LMT4 unused
    cfg_used = 5'b00011;
    cfg_wg   = 10'b00_00_00_01_01;
    cfg_dg   = {3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
    repeat (3) tick();
    check("rst_ready", lmt_entry_ready, 1'b1);
    check("rst_valid", pmt_wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_err", err_cnt, 8'd0);
    check("rst_data", {pmt_wr_data, pmt_wr_mask, pmt_wr_col}, 66'd0);
    rst = 1'b0;
    tick();

    // Two-slice write to LMT0, with first-write latency
    pmt_wr_ready = 1'b1;
    send_entry(3'd0, 9'd10, 64'hAABBCCDDEEFF0000, 64'hFFFFFFFFFFFF0000);
    check("lat_e0", pmt_wr_valid, 1'b0);
    tick();
    check("lat_e1", pmt_wr_valid, 1'b0);
    tick();
    check("lat_e2", pmt_wr_valid, 1'b1);
    check("lat_word", {pmt_wr_col, pmt_wr_blk, pmt_wr_addr, pmt_wr_data},
          {2'd0, 3'd0, 5'd10, 32'hAABBCCDD});
    wait_idle(1'b0);
    check("drain_028", exp_q.size(), 0);

    // LMT1 addr 200 -> block 6 row 8
    send_entry(3'd1, 9'd200, 64'h0123456789ABCDEF, 64'hF0F0F0F00F0F0F0F);
    wait_idle(1'b0);
    check("drain_029", exp_q.size(), 0);

    // Illegal entries: block out of range, then unused LMT
    cfg_dg[5:3] = 3'd2;
    send_entry(3'd1, 9'd128, 64'h1111, 64'h2222);
    wait_idle(1'b0);
    check("err_030a", err_cnt, 8'd1);
    send_entry(3'd4, 9'd0, 64'h3333, 64'h4444);
    wait_idle(1'b0);
    check("err_030b", err_cnt, 8'd2);
    check("err_model", err_cnt, exp_err);
    check("drain_030", exp_q.size(), 0);

    // Six back-to-back entries against a stalled write port
    pmt_wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lmt_entry_valid = 1'b1;
      lmt_entry_id    = 3'd0;
      lmt_entry_addr  = 9'(i * 5);
      lmt_entry_data  = {$urandom, $urandom};
      lmt_entry_mask  = {$urandom, $urandom};
      check("ready_031", lmt_entry_ready, (i < 5));
      if (i < 5) model_push();
      else exp_drop++;
      tick();
    end
    lmt_entry_valid = 1'b0;
    check("full_031", lmt_entry_ready, 1'b0);
    check("drop_031", drop_cnt, 8'd1);
    repeat (2) tick();
    pmt_wr_ready = 1'b1;
    wait_idle(1'b0);
    check("drain_031", exp_q.size(), 0);

    // Randomized bursts of at most FIFO_DEPTH entries from idle
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        cfg_used = 5'($urandom) | 5'($urandom);
        for (int l = 0; l < 5; l++) begin
          cfg_wg[l*2 +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3))
                                                          : 2'($urandom_range(0, 1));
          cfg_dg[l*3 +: 3] = 3'($urandom_range(0, 7));
        end
        pmt_wr_ready    = ($urandom_range(0, 3) != 0);
        lmt_entry_valid = 1'b1;
        lmt_entry_id    = 3'($urandom_range(0, 7));
        lmt_entry_addr  = 9'($urandom);
        lmt_entry_data  = {$urandom, $urandom};
        lmt_entry_mask  = {$urandom, $urandom};
        check("rnd_ready", lmt_entry_ready, 1'b1);
        model_push();
        tick();
        lmt_entry_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          pmt_wr_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      wait_idle(1'b1);
      check("rnd_drain", exp_q.size(), 0);
      check("rnd_err", err_cnt, exp_err);
      check("rnd_drop", drop_cnt, exp_drop);
    end

    cfg_used = 5'b00011;
    cfg_wg   = 10'b00_00_00_01_01;
    cfg_dg   = {3'd0, 3'd0, 3'd0, 3'd3, 3'd0};

`ifdef LMT_WR_PARITY_EN
    cfg_wg[1:0]  = 2'd0;
    pmt_wr_ready = 1'b0;
    send_entry(3'd0, 9'd1, 64'h0000000100000000, 64'd0);
    wait_valid();
    check("parity_033", pmt_wr_parity, 1'b1);
    pmt_wr_ready = 1'b1;
    wait_idle(1'b0);
    cfg_wg[1:0] = 2'd1;
`endif

    // Drop counter saturation, then reset during col0 of a two-slice write
    pmt_wr_ready = 1'b0;
    for (int i = 0; i < 270; i++) begin
      lmt_entry_valid = 1'b1;
      lmt_entry_id    = 3'd0;
      lmt_entry_addr  = 9'd3;
      lmt_entry_data  = {$urandom, $urandom};
      lmt_entry_mask  = {$urandom, $urandom};
      if (i < 5) model_push();
      else if (exp_drop < 255) exp_drop++;
      tick();
    end
    lmt_entry_valid = 1'b0;
    check("drop_sat", drop_cnt, 8'd255);
    check("drop_sat_model", drop_cnt, exp_drop);
    check("pre_rst_col0", {pmt_wr_valid, pmt_wr_col}, {1'b1, 2'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_err  = 0;
    exp_drop = 0;
    check("post_rst_valid", pmt_wr_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_drop", drop_cnt, 8'd0);
    check("post_rst_err", err_cnt, 8'd0);
    check("post_rst_ready", lmt_entry_ready, 1'b1);
    check("post_rst_data", {pmt_wr_data, pmt_wr_mask}, 64'd0);
    pmt_wr_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_quiet", pmt_wr_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
